// File: rtl/reg_file_pkg.sv
// Shared widths and architectural register indices for the integer register file.
package reg_file_pkg;

    localparam int XLEN   = 32;
    localparam int XADDR  = 5;
    localparam int REG_X0 = 0;
    localparam int REG_SP = 2;

endpackage

// File: rtl/reg_scoreboard.sv
// Write-pending scoreboard: one busy bit per register plus the read-after-write stall compare.
// REGFILE_BYPASS_EN: a same-cycle write-back to rsK resolves that operand's hazard.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = XADDR
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [ADDR_W-1:0]      i_rd_addr,
    input  logic                   i_rd_write,
    input  logic [ADDR_W-1:0]      i_rs1_addr,
    input  logic [ADDR_W-1:0]      i_rs2_addr,
    input  logic                   i_issue_valid,
    input  logic [ADDR_W-1:0]      i_issue_rd,
    input  logic                   i_flush,
    output logic [2**ADDR_W-1:0]   or_busy,
    output logic                   o_stall
);

    logic [2**ADDR_W-1:0] r_busy;
    logic                 w_hit1;
    logic                 w_hit2;

    // Priority per bit: flush, then a new issue (younger owner), then write-back clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            for (int n = 0; n < 2**ADDR_W; n++) begin
                if (n == REG_X0)
                    r_busy[n] <= 1'b0;
                else if (i_flush)
                    r_busy[n] <= 1'b0;
                else if (i_issue_valid && i_issue_rd == ADDR_W'(n))
                    r_busy[n] <= 1'b1;
                else if (i_rd_write && i_rd_addr == ADDR_W'(n))
                    r_busy[n] <= 1'b0;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign w_hit1 = i_rd_write && (i_rd_addr == i_rs1_addr);
    assign w_hit2 = i_rd_write && (i_rd_addr == i_rs2_addr);
`else
    assign w_hit1 = 1'b0;
    assign w_hit2 = 1'b0;
`endif

    assign o_stall = (r_busy[i_rs1_addr] && !w_hit1) || (r_busy[i_rs2_addr] && !w_hit2);
    assign or_busy = r_busy;

endmodule

// File: rtl/reg_file.sv
// Integer register file: async-reset storage, two combinational read ports, scoreboard instance.
// REGFILE_BYPASS_EN: forward same-cycle write-back data onto the read ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int                DATA_W  = XLEN,
    parameter int                ADDR_W  = XADDR,
    parameter logic [DATA_W-1:0] SP_INIT = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [ADDR_W-1:0]      i_rd_addr,
    input  logic                   i_rd_write,
    input  logic [DATA_W-1:0]      i_rd_data,
    input  logic [ADDR_W-1:0]      i_rs1_addr,
    input  logic [ADDR_W-1:0]      i_rs2_addr,
    input  logic                   i_issue_valid,
    input  logic [ADDR_W-1:0]      i_issue_rd,
    input  logic                   i_flush,
    output logic [DATA_W-1:0]      o_rs1_data,
    output logic [DATA_W-1:0]      o_rs2_data,
    output logic [2**ADDR_W-1:0]   or_busy,
    output logic                   o_stall
);

    logic [DATA_W-1:0] r_regs [0:2**ADDR_W-1];
    logic [ADDR_W-1:0] w_rs_addr [0:1];

    // Reset must be visible without a clock edge, so the array carries an async reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int n = 0; n < 2**ADDR_W; n++)
                r_regs[n] <= (n == REG_SP) ? SP_INIT : '0;
        end else if (i_rd_write && i_rd_addr != ADDR_W'(REG_X0)) begin
            r_regs[i_rd_addr] <= i_rd_data;
        end
    end

    assign w_rs_addr[0] = i_rs1_addr;
    assign w_rs_addr[1] = i_rs2_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic              w_fwd;
            logic [DATA_W-1:0] w_data;
`ifdef REGFILE_BYPASS_EN
            assign w_fwd = i_rd_write && (i_rd_addr == w_rs_addr[gi]) &&
                           (w_rs_addr[gi] != ADDR_W'(REG_X0));
`else
            assign w_fwd = 1'b0;
`endif
            assign w_data = (w_rs_addr[gi] == ADDR_W'(REG_X0)) ? '0 :
                            w_fwd                              ? i_rd_data :
                                                                 r_regs[w_rs_addr[gi]];
        end
    endgenerate

    assign o_rs1_data = g_rd[0].w_data;
    assign o_rs2_data = g_rd[1].w_data;

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_rd_addr     (i_rd_addr),
        .i_rd_write    (i_rd_write),
        .i_rs1_addr    (i_rs1_addr),
        .i_rs2_addr    (i_rs2_addr),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .i_flush       (i_flush),
        .or_busy       (or_busy),
        .o_stall       (o_stall)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, async-reset sequence, randomized model check.
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [31:0] SP_VAL = 32'h0000_8000;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr;
    logic        rd_write;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] busy;
    logic        stall;

    int n_vec  = 0;
    int n_miss = 0;

    reg_file #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .SP_INIT (SP_VAL)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rd_addr     (rd_addr),
        .i_rd_write    (rd_write),
        .i_rd_data     (rd_data),
        .i_rs1_addr    (rs1_addr),
        .i_rs2_addr    (rs2_addr),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_flush       (flush),
        .o_rs1_data    (rs1_data),
        .o_rs2_data    (rs2_data),
        .or_busy       (busy),
        .o_stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        iv;
        logic [4:0]  ird;
        logic        fl;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic        e_stall;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [4:0] rd, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic iv, input logic [4:0] ird, input logic fl);
        rd_write = wr; rd_addr = rd; rd_data = wd;
        rs1_addr = r1; rs2_addr = r2;
        issue_valid = iv; issue_rd = ird; flush = fl;
    endtask

    // Reference state for the random phase
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (BYP && rd_write && rd_addr == a) return rd_data;
        return m_regs[a];
    endfunction

    function automatic logic m_stall();
        bit s1, s2;
        s1 = m_busy[rs1_addr] && !(BYP && rd_write && rd_addr == rs1_addr);
        s2 = m_busy[rs2_addr] && !(BYP && rd_write && rd_addr == rs2_addr);
        return s1 || s2;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        for (int n = 0; n < 32; n++) v[n] = m_busy[n];
        return v;
    endfunction

    task automatic m_commit();
        if (rd_write && rd_addr != 5'd0) m_regs[rd_addr] = rd_data;
        // Apply in ascending priority so later rules override earlier ones
        if (rd_write) m_busy[rd_addr] = 1'b0;
        if (issue_valid) m_busy[issue_rd] = 1'b1;
        if (flush) for (int n = 0; n < 32; n++) m_busy[n] = 1'b0;
        m_busy[0] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd1, 1'b0, 5'd0, 1'b0);

        vecs[0]  = '{1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0,
                     BYP ? 32'hDEAD_BEEF : 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0,
                     32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0,
                     32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                     32'h0, 32'h0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b1, 5'd7, 1'b0,
                     32'h0, 32'h0, 1'b0, 32'h0000_0080};
        vecs[5]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0,
                     32'h0, 32'h0, 1'b1, 32'h0000_0080};
        vecs[6]  = '{1'b1, 5'd7, 32'h0000_0042, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0,
                     32'h0, BYP ? 32'h42 : 32'h0, !BYP, 32'h0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0,
                     32'h0, 32'h42, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 5'd3, 32'h0000_0033, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0,
                     BYP ? 32'h33 : 32'h0, 32'h0, 1'b0, 32'h0000_0008};
        vecs[9]  = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0,
                     32'h33, 32'h0, 1'b1, 32'h0000_0008};
        vecs[10] = '{1'b1, 5'd3, 32'h0000_0034, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0,
                     BYP ? 32'h34 : 32'h33, 32'h0, !BYP, 32'h0};
        vecs[11] = '{1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0,
                     32'h0, 32'h0, 1'b0, 32'h0000_0010};
        vecs[12] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0,
                     32'h0, 32'h0, 1'b0, 32'h0000_0210};
        vecs[13] = '{1'b0, 5'd0, 32'h0, 5'd4, 5'd9, 1'b1, 5'd4, 1'b1,
                     32'h0, 32'h0, 1'b1, 32'h0};
        vecs[14] = '{1'b0, 5'd0, 32'h0, 5'd4, 5'd9, 1'b0, 5'd0, 1'b0,
                     32'h0, 32'h0, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0,
                     32'h0, 32'h34, 1'b0, 32'h0};

        // Reset state, checked while reset is held
        #12;
        chk("reset_x2", rs1_data, SP_VAL);
        chk("reset_x1", rs2_data, 32'h0);
        rs1_addr = 5'd31; #1;
        chk("reset_x31", rs1_data, 32'h0);
        chk("reset_busy", busy, 32'h0);
        chk("reset_stall", {31'h0, stall}, 32'h0);
        $display("reset: x2=%h x1=%h busy=%h", SP_VAL, rs2_data, busy);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].wd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].iv, vecs[i].ird, vecs[i].fl);
            @(negedge clk);
            chk($sformatf("v%0d_rs1", i), rs1_data, vecs[i].e_rs1);
            chk($sformatf("v%0d_rs2", i), rs2_data, vecs[i].e_rs2);
            chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vecs[i].e_stall});
            @(posedge clk); #1;
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            $display("vec %0d: wr=%b rd=%0d rs1=%0d rs2=%0d iv=%b ird=%0d fl=%b stall=%b busy=%h",
                     i, vecs[i].wr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].iv,
                     vecs[i].ird, vecs[i].fl, stall, busy);
        end

        // Async reset while a stall is active
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd6, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd5, 1'b0, 5'd0, 1'b0);
        #1;
        chk("pre_rst_stall", {31'h0, stall}, 32'h1);
        chk("pre_rst_x5", rs2_data, 32'hDEAD_BEEF);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_stall", {31'h0, stall}, 32'h0);
        chk("async_rst_busy", busy, 32'h0);
        chk("async_rst_x5", rs2_data, 32'h0);
        rs2_addr = 5'd2; #1;
        chk("async_rst_x2", rs2_data, SP_VAL);
        $display("async reset: stall=%b busy=%h x2=%h", stall, busy, rs2_data);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_stall", {31'h0, stall}, 32'h0);

        // Randomized phase against the reference model, starting from reset state
        for (int n = 0; n < 32; n++) begin
            m_regs[n] = (n == 2) ? SP_VAL : 32'h0;
            m_busy[n] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 15) == 0);
            @(negedge clk);
            chk($sformatf("rnd%0d_rs1", c), rs1_data, m_read(rs1_addr));
            chk($sformatf("rnd%0d_rs2", c), rs2_data, m_read(rs2_addr));
            chk($sformatf("rnd%0d_stall", c), {31'h0, stall}, {31'h0, m_stall()});
            @(posedge clk);
            m_commit();
            #1;
            chk($sformatf("rnd%0d_busy", c), busy, m_busy_vec());
            $display("rnd %0d: wr=%b rd=%0d iv=%b ird=%0d fl=%b busy=%h",
                     c, rd_write, rd_addr, issue_valid, issue_rd, flush, busy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
